// File: rtl/core_seq_ctrl_pkg.sv
// Shared types and constants for the core sequencer.
package core_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StWaitRsp,
    StExec,
    StCommit,
    StHalt
  } state_e;

  localparam logic [1:0] HaltRun      = 2'd0;
  localparam logic [1:0] HaltEbreak   = 2'd1;
  localparam logic [1:0] HaltFetch    = 2'd2;
  localparam logic [1:0] HaltMisalign = 2'd3;

  localparam logic [31:0] NopInst        = 32'h0000_0013;
  localparam logic [31:0] DefaultResetPc = 32'h8000_0000;

endpackage

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: fetch over valid/ready, hold inst for EXU, commit, pick next PC, halt.
module core_seq_ctrl
  import core_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = DefaultResetPc,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        imem_rsp_err_i,
  output logic [31:0] inst_o,
  input  logic        is_ebreak_i,
  output logic        exu_start_o,
  input  logic        exu_done_i,
  input  logic        exu_wen_i,
  output logic        rf_wen_o,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] pc_o,
  output logic [63:0] instret_o,
  output logic        halted_o,
  output logic [1:0]  halt_code_o
);

  localparam logic [15:0] TmoLimit = 16'(FETCH_TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] instret_q, instret_d;
  logic [1:0]  halt_code_q, halt_code_d;
  logic [15:0] tmo_q, tmo_d;
  logic        first_q, first_d;
  // Low for the first cycle out of reset so no request is presented while rst_ni is asserted.
  logic        live_q;

  // Next-state, PC selection, commit bookkeeping and timeout counting.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    instret_d   = instret_q;
    halt_code_d = halt_code_q;
    tmo_d       = tmo_q;
    first_d     = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (live_q && imem_req_ready_i) begin
          state_d = StWaitRsp;
          tmo_d   = '0;
        end
      end
      StWaitRsp: begin
        if (imem_rsp_valid_i) begin
          if (imem_rsp_err_i) begin
            state_d     = StHalt;
            halt_code_d = HaltFetch;
          end else begin
            inst_d  = imem_rsp_data_i;
            state_d = StExec;
            first_d = 1'b1;
          end
        end else begin
          tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
          if (tmo_d >= TmoLimit) begin
            state_d     = StHalt;
            halt_code_d = HaltFetch;
          end
        end
      end
      StExec: begin
        if (exu_done_i) state_d = StCommit;
      end
      StCommit: begin
        instret_d = instret_q + 64'd1;
        if (is_ebreak_i) begin
          state_d     = StHalt;
          halt_code_d = HaltEbreak;
        end else if (branch_taken_i && (branch_target_i[1:0] != 2'b00)) begin
          state_d     = StHalt;
          halt_code_d = HaltMisalign;
        end else begin
          pc_d    = branch_taken_i ? branch_target_i : pc_q + 32'd4;
          state_d = StFetch;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StFetch;
      pc_q        <= RESET_PC;
      inst_q      <= NopInst;
      instret_q   <= '0;
      halt_code_q <= HaltRun;
      tmo_q       <= '0;
      first_q     <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      instret_q   <= instret_d;
      halt_code_q <= halt_code_d;
      tmo_q       <= tmo_d;
      first_q     <= first_d;
      live_q      <= 1'b1;
    end
  end

  // Output decodes from registered state; exu_start and rf_wen live in disjoint states.
  always_comb begin
    imem_req_valid_o = live_q && (state_q == StFetch);
    imem_req_addr_o  = pc_q;
    exu_start_o      = (state_q == StExec) && first_q;
    rf_wen_o         = (state_q == StCommit) && !is_ebreak_i && exu_wen_i;
    inst_o           = inst_q;
    pc_o             = pc_q;
    instret_o        = instret_q;
    halted_o         = (state_q == StHalt);
    halt_code_o      = halt_code_q;
  end

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench: bench acts as instruction memory, IDU and EXU; an instruction-level model
// predicts fetch addresses, writeback strobes, retire count and halt codes.
module tb_core_seq_ctrl;

  localparam logic [31:0] ResetPc = 32'h8000_0000;
  localparam int unsigned Tmo     = 8;
  localparam logic [31:0] Nop     = 32'h0000_0013;
  localparam logic [31:0] Ebreak  = 32'h0010_0073;

  logic        clk, rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic        is_ebreak, exu_start, exu_done, exu_wen, rf_wen, branch_taken;
  logic [31:0] branch_target, pc;
  logic [63:0] instret;
  logic        halted;
  logic [1:0]  halt_code;

  core_seq_ctrl #(
    .RESET_PC      (ResetPc),
    .FETCH_TIMEOUT (Tmo)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .imem_rsp_err_i   (imem_rsp_err),
    .inst_o           (inst),
    .is_ebreak_i      (is_ebreak),
    .exu_start_o      (exu_start),
    .exu_done_i       (exu_done),
    .exu_wen_i        (exu_wen),
    .rf_wen_o         (rf_wen),
    .branch_taken_i   (branch_taken),
    .branch_target_i  (branch_target),
    .pc_o             (pc),
    .instret_o        (instret),
    .halted_o         (halted),
    .halt_code_o      (halt_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Architectural model.
  logic [31:0] m_pc, m_inst;
  logic [63:0] m_instret;
  logic [1:0]  m_code;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    is_ebreak      = 1'b0;
    exu_done       = 1'b0;
    exu_wen        = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
  endtask

  task automatic check_arch(input string tag);
    chk({tag, "_halted"}, 64'(halted), 64'(m_code != 2'd0));
    chk({tag, "_code"}, 64'(halt_code), 64'(m_code));
    chk({tag, "_pc"}, 64'(pc), 64'(m_pc));
    chk({tag, "_instret"}, instret, m_instret);
  endtask

  // Leaves the bench at a negedge with the DUT in its first live FETCH cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    m_pc = ResetPc; m_inst = Nop; m_instret = '0; m_code = 2'd0;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_exu_start", 64'(exu_start), 64'd0);
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_inst", 64'(inst), 64'(Nop));
    check_arch("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One full instruction from FETCH through COMMIT; ends at the following negedge.
  task automatic do_inst(input logic [31:0] data, input bit wen, input bit br,
                         input logic [31:0] tgt, input int req_wait, input int rsp_wait,
                         input int exu_lat);
    bit eb;
    eb = (data == Ebreak);
    for (int i = 0; i < req_wait; i++) begin
      imem_req_ready = 1'b0;
      #1;
      chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
      chk("stall_req_addr", 64'(imem_req_addr), 64'(m_pc));
      @(negedge clk);
    end
    imem_req_ready = 1'b1;
    #1;
    chk("req_valid", 64'(imem_req_valid), 64'd1);
    chk("req_addr", 64'(imem_req_addr), 64'(m_pc));
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_wait; i++) begin
      #1;
      chk("wait_req_valid", 64'(imem_req_valid), 64'd0);
      @(negedge clk);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    m_inst    = data;
    is_ebreak = eb;
    for (int i = 0; i < exu_lat; i++) begin
      exu_done = (i == exu_lat - 1);
      #1;
      chk("exec_start", 64'(exu_start), 64'(i == 0));
      chk("exec_inst", 64'(inst), 64'(m_inst));
      chk("exec_rf_wen", 64'(rf_wen), 64'd0);
      @(negedge clk);
    end
    exu_done      = 1'b0;
    exu_wen       = wen;
    branch_taken  = br;
    branch_target = tgt;
    #1;
    chk("commit_rf_wen", 64'(rf_wen), 64'(wen && !eb));
    chk("commit_start", 64'(exu_start), 64'd0);
    chk("commit_pc", 64'(pc), 64'(m_pc));
    @(negedge clk);
    clear_inputs();
    m_instret = m_instret + 64'd1;
    if (eb) m_code = 2'd1;
    else if (br && (tgt[1:0] != 2'b00)) m_code = 2'd3;
    else m_pc = br ? tgt : m_pc + 32'd4;
    check_arch("post_commit");
  endtask

  task automatic hold_halt(input int n);
    for (int i = 0; i < n; i++) begin
      imem_req_ready = 1'b1; imem_rsp_valid = 1'b1; exu_done = 1'b1;
      exu_wen = 1'b1; branch_taken = 1'b1;
      #1;
      chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
      chk("halt_exu_start", 64'(exu_start), 64'd0);
      chk("halt_rf_wen", 64'(rf_wen), 64'd0);
      chk("halt_inst", 64'(inst), 64'(m_inst));
      check_arch("halt");
      @(negedge clk);
    end
    clear_inputs();
  endtask

  initial begin
    int unsigned t0;
    logic [31:0] d, t;
    bit b;
    rst_n = 1'b0;
    clear_inputs();

    // Three zero-wait addi: 4 cycles each.
    do_reset();
    t0 = cyc;
    do_inst(32'h0010_0093, 1'b1, 1'b0, '0, 0, 0, 1);
    do_inst(32'h0020_0113, 1'b1, 1'b0, '0, 0, 0, 1);
    do_inst(32'h0030_0193, 1'b1, 1'b0, '0, 0, 0, 1);
    chk("three_inst_cycles", 64'(cyc - t0), 64'd12);
    chk("three_inst_instret", instret, 64'd3);

    // Request held off for 5 cycles.
    do_inst(32'h0040_0213, 1'b1, 1'b0, '0, 5, 0, 1);

    // Aligned branch, then PC wrap at top of address space.
    do_inst(32'h0000_0063, 1'b0, 1'b1, 32'h8000_0100, 0, 0, 1);
    do_inst(32'h0000_0063, 1'b0, 1'b1, 32'hFFFF_FFFC, 0, 1, 2);
    do_inst(32'h0050_0293, 1'b1, 1'b0, '0, 0, 0, 1);
    chk("pc_wrap", 64'(pc), 64'd0);
    do_inst(32'h0000_0063, 1'b0, 1'b1, ResetPc, 1, 0, 1);

    // Randomised traffic with aligned branches.
    for (int k = 0; k < 40; k++) begin
      d = $urandom;
      if (d == Ebreak) d = Nop;
      b = ($urandom_range(0, 3) == 0);
      t = $urandom & 32'hFFFF_FFFC;
      do_inst(d, 1'($urandom_range(0, 1)), b, t, $urandom_range(0, 3),
              $urandom_range(0, Tmo - 2), $urandom_range(1, 4));
    end

    // Misaligned branch target halts with pc held.
    do_inst(32'h0000_0063, 1'b1, 1'b1, 32'h8000_0102, 0, 0, 1);
    hold_halt(3);

    // ebreak.
    do_reset();
    do_inst(32'h0010_0093, 1'b1, 1'b0, '0, 0, 0, 1);
    do_inst(Ebreak, 1'b1, 1'b0, '0, 0, 0, 1);
    hold_halt(4);

    // Fetch timeout.
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    for (int i = 0; i < int'(Tmo); i++) begin
      #1;
      chk("tmo_not_halted", 64'(halted), 64'd0);
      @(negedge clk);
    end
    m_code = 2'd2;
    hold_halt(2);

    // Fetch error response.
    do_reset();
    do_inst(32'h0010_0093, 1'b1, 1'b0, '0, 0, 0, 1);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    clear_inputs();
    m_code = 2'd2;
    hold_halt(2);

    // Async reset in the middle of a 5-cycle EXU op.
    do_reset();
    do_inst(32'h0010_0093, 1'b1, 1'b0, '0, 0, 0, 1);
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("mid_exec_start", 64'(exu_start), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_pc", 64'(pc), 64'(ResetPc));
    chk("async_inst", 64'(inst), 64'(Nop));
    chk("async_instret", instret, 64'd0);
    chk("async_strobes", 64'({imem_req_valid, exu_start, rf_wen, halted}), 64'd0);
    chk("async_code", 64'(halt_code), 64'd0);
    do_reset();
    do_inst(32'h0030_0193, 1'b1, 1'b0, '0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
